// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Brief    : HI/LO multiply/divide sequencer: launches the multiplier/divider,
//            stalls the pipeline and writes the result back to HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    input  logic        pipe_adv,
    input  logic        flush,
    output logic        mul_signed,
    output logic        div_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [3:0] C_MUL_CNT_INIT = 4'(MUL_LAT - 1);

    generate
        if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
            $error("mdu_ctrl: MUL_LAT out of range 1..15");
        end
    endgenerate

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_opa, w_opa_nxt;
    logic [31:0] r_opb, w_opb_nxt;
    logic        r_is_mul, w_is_mul_nxt;
    logic        r_is_div, w_is_div_nxt;
    logic        r_mul_signed, w_mul_signed_nxt;
    logic        r_div_signed, w_div_signed_nxt;
    logic        r_hilo_we, w_hilo_we_nxt;
    logic [31:0] r_hi_wdata, w_hi_wdata_nxt;
    logic [31:0] r_lo_wdata, w_lo_wdata_nxt;
    logic        r_div_annul, w_div_annul_nxt;

    logic        w_op_mul;
    logic        w_op_div;

    assign w_op_mul = (op_code == 3'd1) || (op_code == 3'd2);
    assign w_op_div = (op_code == 3'd3) || (op_code == 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_opa        <= 32'd0;
            r_opb        <= 32'd0;
            r_is_mul     <= 1'b0;
            r_is_div     <= 1'b0;
            r_mul_signed <= 1'b0;
            r_div_signed <= 1'b0;
            r_hilo_we    <= 1'b0;
            r_hi_wdata   <= 32'd0;
            r_lo_wdata   <= 32'd0;
            r_div_annul  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_opa        <= w_opa_nxt;
            r_opb        <= w_opb_nxt;
            r_is_mul     <= w_is_mul_nxt;
            r_is_div     <= w_is_div_nxt;
            r_mul_signed <= w_mul_signed_nxt;
            r_div_signed <= w_div_signed_nxt;
            r_hilo_we    <= w_hilo_we_nxt;
            r_hi_wdata   <= w_hi_wdata_nxt;
            r_lo_wdata   <= w_lo_wdata_nxt;
            r_div_annul  <= w_div_annul_nxt;
        end
    end

    // HI/LO write is registered: the data is formed in the cycle before the
    // write appears, so a flush in that cycle cancels it.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_opa_nxt        = r_opa;
        w_opb_nxt        = r_opb;
        w_is_mul_nxt     = r_is_mul;
        w_is_div_nxt     = r_is_div;
        w_mul_signed_nxt = r_mul_signed;
        w_div_signed_nxt = r_div_signed;
        w_hilo_we_nxt    = 1'b0;
        w_hi_wdata_nxt   = 32'd0;
        w_lo_wdata_nxt   = 32'd0;
        w_div_annul_nxt  = 1'b0;

        if (flush) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = 4'd0;
            w_opa_nxt        = 32'd0;
            w_opb_nxt        = 32'd0;
            w_is_mul_nxt     = 1'b0;
            w_is_div_nxt     = 1'b0;
            w_mul_signed_nxt = 1'b0;
            w_div_signed_nxt = 1'b0;
            w_div_annul_nxt  = (r_state == S_DIV_WAIT);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid && w_op_mul) begin
                        w_opa_nxt        = src_a;
                        w_opb_nxt        = src_b;
                        w_is_mul_nxt     = 1'b1;
                        w_mul_signed_nxt = (op_code == 3'd1);
                        w_cnt_nxt        = C_MUL_CNT_INIT;
                        w_state_nxt      = S_MUL_WAIT;
                    end else if (op_valid && w_op_div && (src_b != 32'd0)) begin
                        w_opa_nxt        = src_a;
                        w_opb_nxt        = src_b;
                        w_is_div_nxt     = 1'b1;
                        w_div_signed_nxt = (op_code == 3'd3);
                        w_state_nxt      = S_DIV_WAIT;
                    end else if (op_valid && w_op_div) begin
                        w_hilo_we_nxt  = 1'b1;
                        w_hi_wdata_nxt = src_a;
                        w_lo_wdata_nxt = 32'hFFFF_FFFF;
                        w_state_nxt    = S_DONE;
                    end else if (op_valid && (op_code == 3'd5)) begin
                        w_hilo_we_nxt  = 1'b1;
                        w_hi_wdata_nxt = src_a;
                        w_lo_wdata_nxt = lo_cur;
                    end else if (op_valid && (op_code == 3'd6)) begin
                        w_hilo_we_nxt  = 1'b1;
                        w_hi_wdata_nxt = hi_cur;
                        w_lo_wdata_nxt = src_a;
                    end
                end
                S_MUL_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        w_hilo_we_nxt  = 1'b1;
                        w_hi_wdata_nxt = mul_result[63:32];
                        w_lo_wdata_nxt = mul_result[31:0];
                        w_state_nxt    = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                S_DIV_WAIT: begin
                    if (div_ready) begin
                        w_hilo_we_nxt  = 1'b1;
                        w_hi_wdata_nxt = div_result[63:32];
                        w_lo_wdata_nxt = div_result[31:0];
                        w_state_nxt    = S_DONE;
                    end
                end
                S_DONE: begin
                    if (pipe_adv) begin
                        w_state_nxt      = S_IDLE;
                        w_opa_nxt        = 32'd0;
                        w_opb_nxt        = 32'd0;
                        w_is_mul_nxt     = 1'b0;
                        w_is_div_nxt     = 1'b0;
                        w_mul_signed_nxt = 1'b0;
                        w_div_signed_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign stallreq   = ((r_state == S_IDLE) && op_valid && (w_op_mul || w_op_div) && !flush)
                      || (r_state == S_MUL_WAIT) || (r_state == S_DIV_WAIT);
    assign busy       = (r_state != S_IDLE);
    assign div_start  = (r_state == S_DIV_WAIT);
    assign div_annul  = r_div_annul;
    assign mul_signed = r_mul_signed;
    assign div_signed = r_div_signed;
    assign mul_ina    = r_is_mul ? r_opa : 32'd0;
    assign mul_inb    = r_is_mul ? r_opb : 32'd0;
    assign div_opa    = r_is_div ? r_opa : 32'd0;
    assign div_opb    = r_is_div ? r_opb : 32'd0;
    assign hilo_we    = r_hilo_we;
    assign hi_wdata   = r_hi_wdata;
    assign lo_wdata   = r_lo_wdata;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2: fixed multiplier latency in cycles; legal range 1..15.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op_valid  in  1  EX stage holds a HI/LO-class instruction.
REQ-005 op_code  in  3  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; other values are no-op.
REQ-006 src_a, src_b  in  32 each  operands (rs, rt).
REQ-007 hi_cur, lo_cur  in  32 each  current HI/LO values, forwarded.
REQ-008 pipe_adv  in  1  EX will advance this cycle if this block does not stall.
REQ-009 flush  in  1  kill the EX instruction.
REQ-010 mul_signed, div_signed  out  1 each  signedness to the units.
REQ-011 mul_ina, mul_inb, div_opa, div_opb  out  32 each  latched operands.
REQ-012 mul_result  in  64  multiplier output, valid MUL_LAT cycles after operands are applied.
REQ-013 div_start  out  1; div_annul  out  1; div_ready  in  1; div_result  in  64 ({rem,quot}).
REQ-014 stallreq  out  1  hold IF..EX.
REQ-015 hilo_we  out  1; hi_wdata, lo_wdata  out  32 each  HI/LO write port.
REQ-016 busy  out  1  state != IDLE.

Function
REQ-017 States: IDLE, MUL_WAIT, DIV_WAIT, DONE; 4-bit down-counter cnt.
REQ-018 IDLE, op_valid, op 1/2, no flush: latch operands and signedness; cnt=MUL_LAT-1; go MUL_WAIT.
REQ-019 IDLE, op 3/4, src_b!=0, no flush: latch operands; div_start=1 from the next cycle until div_ready; go DIV_WAIT.
REQ-020 IDLE, op 3/4, src_b==0: no divider launch; go DONE with result {hi,lo}={src_a, 32'hFFFF_FFFF}.
REQ-021 IDLE, op 5/6: stay IDLE; next cycle hilo_we=1 with {src_a, lo_cur} (mthi) or {hi_cur, src_a} (mtlo); this write repeats each cycle the op is held and is idempotent; stallreq stays 0.
REQ-022 MUL_WAIT: cnt decrements each cycle; at cnt==0, capture mul_result and go DONE.
REQ-023 DIV_WAIT: on div_ready=1, capture div_result; deassert div_start; go DONE.
REQ-024 DONE: hilo_we=1 with the captured result on the first DONE cycle only; stay in DONE while pipe_adv=0; go IDLE when pipe_adv=1; op_valid is ignored in DONE.
REQ-025 stallreq = (IDLE & op_valid & op in 1..4 & !flush) | MUL_WAIT | DIV_WAIT; 0 in DONE; combinational.
REQ-026 Signed multiply is a 64-bit two's-complement product; unsigned zero-extends; MUL_LAT=1 reaches DONE one cycle after acceptance.
REQ-027 Flush has priority over every event: any state goes to IDLE next cycle; the pending hilo_we is suppressed; div_annul=1 for one cycle if the state was DIV_WAIT; div_start drops.
REQ-028 Flush in IDLE blocks acceptance that cycle; flush on the div_ready cycle means no write.
REQ-029 Operand outputs hold their latched values while busy; they are 0 in IDLE.

Reset
REQ-030 On rst: state IDLE, cnt 0; all outputs 0, including hilo_we, stallreq, div_start, div_annul, and all data outputs.
REQ-031 rst mid-operation aborts with no hilo_we and no div_annul; the divider is reset by the same rst.

Verification
REQ-032 mult, src_a=-3 (0xFFFFFFFD), src_b=5, MUL_LAT=2 -> stallreq for 3 cycles; DONE hilo_we=1 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 divu 100/7, model asserts div_ready after 33 cycles -> stallreq held throughout; div_start high until ready; hilo_we once with hi=2, lo=14.
REQ-034 div src_b=0, src_a=0x12345678 -> one stall cycle, no div_start; hilo_we with hi=0x12345678, lo=0xFFFFFFFF.
REQ-035 div in progress, flush at cycle 10 -> div_annul pulse of 1 cycle, IDLE next cycle, hilo_we never asserted, stallreq 0.
REQ-036 multu done with pipe_adv=0 for 3 cycles -> stays in DONE 4 cycles, hilo_we exactly once, stallreq 0 throughout DONE.
REQ-037 mthi src_a=0xA5A5A5A5, lo_cur=7 -> next cycle hilo_we=1, hi=0xA5A5A5A5, lo=7, stallreq never asserted.
